// File: rtl/reg_mem_pkg.sv
// reg_mem_pkg: shared FSM states, constants and parameter checks for the SRAM adapter
package reg_mem_pkg;
  typedef enum logic [2:0] {INIT, IDLE, ACCESS, RD_WAIT, ACK, DROP} state_t;
  localparam int ERR_CNT_WIDTH = 8;
  function automatic bit rd_latency_ok(input int lat);
    return lat >= 1 && lat <= 4;
  endfunction
endpackage

// File: rtl/reg_mem_init_seq.sv
// reg_mem_init_seq: address counter and done flag for the post-reset SRAM init sweep
module reg_mem_init_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter bit ENABLE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last,
  output logic                  done
);
  logic fin;
  assign last = addr == '1;
  // done trails the final write by one edge; with the sweep disabled it rises on the first edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      fin  <= 1'b0;
      done <= 1'b0;
    end else begin
      addr <= en ? addr + 1'b1 : addr;
      fin  <= en & last;
      done <= done | fin | !ENABLE;
    end
endmodule

// File: rtl/reg_mem_sram_adapter.sv
// reg_mem_sram_adapter: serves held-level bridge requests against a fixed-latency synchronous SRAM
module reg_mem_sram_adapter
  import reg_mem_pkg::*;
#(
  parameter int                        MEM_DATA_WIDTH = 64,
  parameter int                        MEM_ADDR_WIDTH = 5,
  parameter int                        RD_LATENCY     = 1,
  parameter int                        INIT_ON_RESET  = 1,
  parameter logic [MEM_DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_req_vld,
  output logic                      mem_ack_vld,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_wr_en,
  input  logic                      mem_rd_en,
  input  logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
  output logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [MEM_DATA_WIDTH-1:0] sram_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] sram_rdata,
  output logic                      init_done,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);
  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("RD_LATENCY must be within 1..4");
  end
  localparam state_t RST_STATE = INIT_ON_RESET != 0 ? INIT : IDLE;
  state_t state, state_n;
  logic [1:0] lat_cnt, lat_n;
  logic ack_n, ce_n, we_n;
  logic [MEM_ADDR_WIDTH-1:0] addr_n, init_addr;
  logic [MEM_DATA_WIDTH-1:0] wdata_n, rd_n;
  logic [ERR_CNT_WIDTH-1:0] err_n;
  logic init_last;
  reg_mem_init_seq #(.ADDR_WIDTH(MEM_ADDR_WIDTH), .ENABLE(INIT_ON_RESET != 0)) u_init (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == INIT),
    .addr (init_addr),
    .last (init_last),
    .done (init_done)
  );
  always_comb begin
    state_n = state;
    lat_n   = lat_cnt;
    ack_n   = 1'b0;
    ce_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = sram_addr;
    wdata_n = sram_wdata;
    rd_n    = mem_rd_data;
    err_n   = err_cnt;
    case (state)
      INIT: begin
        ce_n    = 1'b1;
        we_n    = 1'b1;
        addr_n  = init_addr;
        wdata_n = INIT_VALUE;
        state_n = init_last ? IDLE : INIT;
      end
      IDLE:
        if (mem_req_vld && (mem_wr_en ^ mem_rd_en)) begin
          ce_n    = 1'b1;
          we_n    = mem_wr_en;
          addr_n  = mem_addr;
          wdata_n = mem_wr_data;
          state_n = ACCESS;
        end else if (mem_req_vld) begin
          ack_n   = 1'b1;
          rd_n    = '0;
          err_n   = err_cnt + ERR_CNT_WIDTH'(err_cnt != '1);
          state_n = DROP;
        end
      ACCESS: begin
        lat_n   = 2'(RD_LATENCY - 1);
        ack_n   = sram_we;
        state_n = sram_we ? ACK : RD_WAIT;
      end
      RD_WAIT:
        if (lat_cnt == 2'd0) begin
          rd_n    = sram_rdata;
          ack_n   = 1'b1;
          state_n = ACK;
        end else begin
          lat_n = lat_cnt - 2'd1;
        end
      ACK: state_n = DROP;
      DROP: state_n = mem_req_vld ? DROP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= RST_STATE;
      lat_cnt     <= '0;
      mem_ack_vld <= 1'b0;
      mem_rd_data <= '0;
      sram_ce     <= 1'b0;
      sram_we     <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      err_cnt     <= '0;
    end else begin
      state       <= state_n;
      lat_cnt     <= lat_n;
      mem_ack_vld <= ack_n;
      mem_rd_data <= rd_n;
      sram_ce     <= ce_n;
      sram_we     <= we_n;
      sram_addr   <= addr_n;
      sram_wdata  <= wdata_n;
      err_cnt     <= err_n;
    end
endmodule

// File: tb/tb_reg_mem_sram_adapter.sv
// tb_reg_mem_sram_adapter: directed checks of init sweep, read/write latency, held/illegal requests and reset abort
module tb_reg_mem_sram_adapter;
  localparam logic [63:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] D5  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D9  = 64'h0BAD_F00D_1234_5678;
  localparam logic [63:0] D12 = 64'hCAFE_0000_BEEF_0012;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_req_vld = 1'b0, mem_wr_en = 1'b0, mem_rd_en = 1'b0;
  logic [4:0] mem_addr = '0, sram_addr;
  logic [63:0] mem_wr_data = '0, mem_rd_data, sram_wdata, sram_rdata;
  logic mem_ack_vld, sram_ce, sram_we, init_done;
  logic [7:0] err_cnt;
  logic [63:0] sram_mem [32];
  logic [63:0] p0, p1;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  reg_mem_sram_adapter #(
    .MEM_DATA_WIDTH(64), .MEM_ADDR_WIDTH(5), .RD_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE(PAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_req_vld(mem_req_vld), .mem_ack_vld(mem_ack_vld),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .init_done(init_done), .err_cnt(err_cnt)
  );
  // two-cycle read latency SRAM: data sampled with ce shows up after the following edge
  always @(posedge clk) begin
    if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
    if (sram_ce && !sram_we) p0 <= sram_mem[sram_addr];
    p1 <= p0;
  end
  assign sram_rdata = p1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic do_req(input logic [4:0] a, input logic w, input logic r, input logic [63:0] d,
                        input int hold, output int ack_cyc, output logic [63:0] rdv,
                        output int ces, output int extra);
    mem_addr = a; mem_wr_en = w; mem_rd_en = r; mem_wr_data = d; mem_req_vld = 1'b1;
    ack_cyc = -1; rdv = 'x; ces = 0; extra = 0;
    for (int k = 1; k <= 20 && ack_cyc < 0; k++) begin
      @(negedge clk);
      ces += int'(sram_ce);
      if (mem_ack_vld) begin ack_cyc = k; rdv = mem_rd_data; end
    end
    repeat (hold) begin
      @(negedge clk);
      extra += int'(mem_ack_vld) + int'(sram_ce);
    end
    mem_req_vld = 1'b0; mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    @(negedge clk);
    extra += int'(mem_ack_vld) + int'(sram_ce);
    @(negedge clk);
  endtask
  task automatic watch_init(output int n, output int bad, output int acks, output logic done);
    logic last31;
    n = 0; bad = 0; acks = 0; done = 1'b0; last31 = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      acks += int'(mem_ack_vld);
      if (init_done) begin
        done = 1'b1;
        if (!last31) bad++;
      end else if (sram_ce && sram_we) begin
        if (sram_addr !== 5'(n) || sram_wdata !== PAT) bad++;
        last31 = sram_addr == 5'd31;
        n++;
      end else if (n > 0) bad++;
    end
  endtask
  initial begin
    int ack_cyc, ces, extra, n, bad, acks, done_cyc;
    logic [63:0] rdv;
    logic done;
    repeat (2) @(negedge clk);
    chk("rst_ack", 64'(mem_ack_vld), 64'd0);
    chk("rst_ce", 64'(sram_ce), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_rd_data", mem_rd_data, 64'd0);
    rst_n = 1'b1;
    watch_init(n, bad, acks, done);
    chk("init_writes", 64'(n), 64'd32);
    chk("init_order", 64'(bad), 64'd0);
    chk("init_done_seen", 64'(done), 64'd1);
    chk("init_no_ack", 64'(acks), 64'd0);
    do_req(5'd7, 1'b0, 1'b1, '0, 0, ack_cyc, rdv, ces, extra);
    chk("rd7_ack_cycle", 64'(ack_cyc), 64'd4);
    chk("rd7_data", rdv, PAT);
    chk("rd7_ce_cycles", 64'(ces), 64'd1);
    chk("rd7_after_ack", 64'(extra), 64'd0);
    do_req(5'd5, 1'b1, 1'b0, D5, 0, ack_cyc, rdv, ces, extra);
    chk("wr5_ack_cycle", 64'(ack_cyc), 64'd2);
    chk("wr5_ce_cycles", 64'(ces), 64'd1);
    chk("wr5_after_ack", 64'(extra), 64'd0);
    chk("wr5_rd_data_held", mem_rd_data, PAT);
    do_req(5'd5, 1'b0, 1'b1, '0, 0, ack_cyc, rdv, ces, extra);
    chk("rd5_ack_cycle", 64'(ack_cyc), 64'd4);
    chk("rd5_data", rdv, D5);
    chk("rd5_after_ack", 64'(extra), 64'd0);
    do_req(5'd9, 1'b1, 1'b0, D9, 10, ack_cyc, rdv, ces, extra);
    chk("held_ack_cycle", 64'(ack_cyc), 64'd2);
    chk("held_ce_cycles", 64'(ces), 64'd1);
    chk("held_no_repeat", 64'(extra), 64'd0);
    do_req(5'd9, 1'b0, 1'b1, '0, 0, ack_cyc, rdv, ces, extra);
    chk("rd9_data", rdv, D9);
    do_req(5'd3, 1'b1, 1'b1, D9, 0, ack_cyc, rdv, ces, extra);
    chk("ill_ack_cycle", 64'(ack_cyc), 64'd1);
    chk("ill_rd_data", rdv, 64'd0);
    chk("ill_no_ce", 64'(ces + extra), 64'd0);
    chk("ill_err_cnt1", 64'(err_cnt), 64'd1);
    do_req(5'd3, 1'b0, 1'b0, '0, 0, ack_cyc, rdv, ces, extra);
    chk("none_ack_cycle", 64'(ack_cyc), 64'd1);
    chk("none_err_cnt2", 64'(err_cnt), 64'd2);
    repeat (298) do_req(5'd3, 1'b1, 1'b1, '0, 0, ack_cyc, rdv, ces, extra);
    chk("sat_ack_cycle", 64'(ack_cyc), 64'd1);
    chk("sat_err_cnt", 64'(err_cnt), 64'd255);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    mem_addr = 5'd12; mem_wr_en = 1'b1; mem_rd_en = 1'b0; mem_wr_data = D12; mem_req_vld = 1'b1;
    ack_cyc = -1; done_cyc = -1;
    for (int i = 0; i < 60 && ack_cyc < 0; i++) begin
      @(negedge clk);
      if (init_done && done_cyc < 0) done_cyc = i;
      if (mem_ack_vld) ack_cyc = i;
    end
    chk("initreq_acked", 64'(ack_cyc >= 0), 64'd1);
    chk("initreq_ack_after_done", 64'(ack_cyc - done_cyc), 64'd1);
    mem_req_vld = 1'b0; mem_wr_en = 1'b0;
    repeat (2) @(negedge clk);
    do_req(5'd12, 1'b0, 1'b1, '0, 0, ack_cyc, rdv, ces, extra);
    chk("rd12_ack_cycle", 64'(ack_cyc), 64'd4);
    chk("rd12_data", rdv, D12);
    mem_addr = 5'd5; mem_rd_en = 1'b1; mem_req_vld = 1'b1;
    @(negedge clk);
    chk("abort_ce_cycle1", 64'(sram_ce), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 64'(mem_ack_vld), 64'd0);
    chk("abort_ce", 64'(sram_ce), 64'd0);
    chk("abort_err_cnt", 64'(err_cnt), 64'd0);
    chk("abort_rd_data", mem_rd_data, 64'd0);
    mem_req_vld = 1'b0; mem_rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    watch_init(n, bad, acks, done);
    chk("reinit_writes", 64'(n), 64'd32);
    chk("reinit_order", 64'(bad), 64'd0);
    chk("reinit_no_ack", 64'(acks), 64'd0);
    chk("reinit_done", 64'(done), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
